spw_light_link_ctrl: RTL and testbench

Link bring-up sequencer and status/control register slave for the SpaceWire light node. It drives the link-start and link-disable controls of the SpaceWire codec, supervises the connecting-to-running handshake with a programmable timeout, bounded retry and back-off, and counts link errors. Software on the Avalon-MM bus reads status and configures the block through four 32-bit registers, replacing the read-only connecting PIO.

---
 rtl/spw_light_link_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_spw_light_link_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spw_light_link_ctrl.sv
// SpaceWire light-node link bring-up sequencer with an Avalon-MM status/control slave.
// Drives codec linkstart/linkdis, supervises Connecting->Run with timeout, bounded retry
// and back-off, counts link errors, and raises a level interrupt on sticky fault bits.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   address, write,       Avalon-MM word address, write strobe and data
//   writedata
//   readdata              registered read data (1-cycle latency, no read strobe)
//   connecting, running   codec state indications
//   link_err              single-cycle codec error pulse
//   linkstart, linkdis    codec link controls
//   irq                   level interrupt
module spw_light_link_ctrl #(
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        connecting,
    input  logic        running,
    input  logic        link_err,
    output logic        linkstart,
    output logic        linkdis,
    output logic        irq
);

    localparam int unsigned ERRCNT_W  = 16;
    localparam int unsigned RETRY_W   = 4;
    localparam int unsigned BACKOFF_W = 4;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
    localparam logic [1:0] ADDR_ERRCNT  = 2'd3;

    localparam logic [RETRY_W-1:0]   RETRY_LIMIT  = RETRY_W'(RETRY_MAX);
    localparam logic [BACKOFF_W-1:0] BACKOFF_LAST = '1;
    localparam logic [ERRCNT_W-1:0]  ERRCNT_SAT   = '1;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_RST  = TIMEOUT_W'(1000);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        CONNECT = 3'd2,
        RUN     = 3'd3,
        BACKOFF = 3'd4,
        FAIL    = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [RETRY_W-1:0]    retry_cnt, retry_nxt, retry_inc;
    logic [TIMEOUT_W-1:0]  timer, timer_nxt;
    logic [BACKOFF_W-1:0]  bo_cnt, bo_nxt;
    logic                  set_failed, set_err;

    logic                  ctrl_enable, ctrl_irq_en;
    logic [TIMEOUT_W-1:0]  timeout_reg;
    logic [ERRCNT_W-1:0]   errcnt;
    logic                  failed, err;
    logic [31:0]           rd_mux;
    logic                  drive_c;

    logic wr_status, wr_control, wr_timeout, wr_errcnt;
    logic unused_wdata;

    assign wr_status    = write && (address == ADDR_STATUS);
    assign wr_control   = write && (address == ADDR_CONTROL);
    assign wr_timeout   = write && (address == ADDR_TIMEOUT);
    assign wr_errcnt    = write && (address == ADDR_ERRCNT);
    assign unused_wdata = ^writedata;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            retry_cnt <= '0;
            timer     <= '0;
            bo_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            timer     <= timer_nxt;
            bo_cnt    <= bo_nxt;
        end
    end

    // Next-state, counters and sticky-set requests.
    always_comb begin
        state_nxt  = state;
        retry_nxt  = retry_cnt;
        retry_inc  = retry_cnt + RETRY_W'(1);
        timer_nxt  = timer;
        bo_nxt     = bo_cnt;
        set_failed = 1'b0;
        set_err    = 1'b0;

        case (state)
            IDLE: begin
                if (ctrl_enable) state_nxt = START;
            end
            START: begin
                timer_nxt = timeout_reg;
                state_nxt = CONNECT;
            end
            CONNECT: begin
                // An error beats running; running beats timeout.
                if (link_err || (!running && (timer == '0))) begin
                    retry_nxt = retry_inc;
                    if (retry_inc == RETRY_LIMIT) begin
                        state_nxt  = FAIL;
                        set_failed = 1'b1;
                    end else begin
                        state_nxt = BACKOFF;
                        bo_nxt    = '0;
                    end
                end else if (running) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end else begin
                    timer_nxt = timer - TIMEOUT_W'(1);
                end
            end
            RUN: begin
                if (!running || link_err) begin
                    set_err   = 1'b1;
                    state_nxt = BACKOFF;
                    bo_nxt    = '0;
                end
            end
            BACKOFF: begin
                if (bo_cnt == BACKOFF_LAST) state_nxt = START;
                else                        bo_nxt    = bo_cnt + BACKOFF_W'(1);
            end
            FAIL: begin
                if (!failed) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Disable overrides everything, including fault recording.
        if (!ctrl_enable) begin
            state_nxt  = IDLE;
            set_failed = 1'b0;
            set_err    = 1'b0;
        end

        if (state_nxt == IDLE) retry_nxt = '0;
    end

    // Codec drive decoded from the next state so the registered outputs track the state.
    assign drive_c = (state_nxt == START) || (state_nxt == CONNECT) || (state_nxt == RUN);

    // Read mux.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:  rd_mux = {14'd0, err, failed, 4'd0, retry_cnt, 3'd0,
                                    3'(state), running, connecting};
            ADDR_CONTROL: rd_mux = {30'd0, ctrl_irq_en, ctrl_enable};
            ADDR_TIMEOUT: rd_mux = 32'(timeout_reg);
            ADDR_ERRCNT:  rd_mux = 32'(errcnt);
            default:      rd_mux = '0;
        endcase
    end

    // Software-visible registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            timeout_reg <= TIMEOUT_RST;
            errcnt      <= '0;
            failed      <= 1'b0;
            err         <= 1'b0;
            irq         <= 1'b0;
            readdata    <= '0;
            linkstart   <= 1'b0;
            linkdis     <= 1'b1;
        end else begin
            if (wr_control) begin
                ctrl_enable <= writedata[0];
                ctrl_irq_en <= writedata[1];
            end
            if (wr_timeout) timeout_reg <= writedata[TIMEOUT_W-1:0];

            // Clear-on-write wins over a coincident error pulse.
            if (wr_errcnt)                           errcnt <= '0;
            else if (link_err && errcnt != ERRCNT_SAT) errcnt <= errcnt + ERRCNT_W'(1);

            // A new fault wins over a coincident W1C.
            failed <= set_failed || (failed && !(wr_status && writedata[16]));
            err    <= set_err    || (err    && !(wr_status && writedata[17]));

            irq       <= ctrl_irq_en && (failed || err);
            readdata  <= rd_mux;
            linkstart <= drive_c;
            linkdis   <= !drive_c;
        end
    end

endmodule

// File: tb/tb_spw_light_link_ctrl.sv
// Directed self-checking bench for spw_light_link_ctrl.
module tb_spw_light_link_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        connecting;
    logic        running;
    logic        link_err;
    logic        linkstart;
    logic        linkdis;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int len;

    spw_light_link_ctrl #(.TIMEOUT_W(16), .RETRY_MAX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .connecting (connecting),
        .running    (running),
        .link_err   (link_err),
        .linkstart  (linkstart),
        .linkdis    (linkdis),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle register write; returns on the negedge after the write edge.
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    // Count negedges while linkstart holds a level, bounded by max.
    task automatic measure(input logic level, input int max, output int n);
        n = 0;
        while (linkstart == level && n < max) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        write      = 1'b0;
        writedata  = '0;
        connecting = 1'b0;
        running    = 1'b0;
        link_err   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values through the register map.
        @(negedge clk); check("rst_status", readdata, 32'h0);
        address = 2'd1; @(negedge clk); check("rst_control", readdata, 32'h0);
        address = 2'd2; @(negedge clk); check("rst_timeout", readdata, 32'd1000);
        address = 2'd3; @(negedge clk); check("rst_errcnt", readdata, 32'h0);
        check("rst_linkdis", 32'(linkdis), 32'h1);
        check("rst_linkstart", 32'(linkstart), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // Normal bring-up to RUN.
        write_reg(2'd2, 32'd10);
        write_reg(2'd1, 32'h1);
        check("en_latency_lo", 32'(linkstart), 32'h0);
        @(negedge clk);
        check("en_latency_hi", 32'(linkstart), 32'h1);
        check("start_linkdis", 32'(linkdis), 32'h0);
        address = 2'd0;
        repeat (5) @(negedge clk);
        running = 1'b1;
        repeat (3) @(negedge clk);
        check("run_status", readdata, 32'h0000_000E);
        check("run_linkstart", 32'(linkstart), 32'h1);

        // Disable first, then drop running, so no RUN error is recorded.
        write_reg(2'd1, 32'h0);
        @(negedge clk);
        running = 1'b0;
        @(negedge clk);

        // Three timed-out attempts with back-off, then FAIL.
        write_reg(2'd2, 32'd4);
        write_reg(2'd1, 32'h3);
        address = 2'd0;
        @(negedge clk);
        measure(1'b1, 40, len); check("att1_high", 32'(len), 32'd6);
        measure(1'b0, 40, len); check("bo1_low",   32'(len), 32'd16);
        measure(1'b1, 40, len); check("att2_high", 32'(len), 32'd6);
        measure(1'b0, 40, len); check("bo2_low",   32'(len), 32'd16);
        measure(1'b1, 40, len); check("att3_high", 32'(len), 32'd6);
        check("fail_irq_lag", 32'(irq), 32'h0);
        @(negedge clk);
        check("fail_irq", 32'(irq), 32'h1);
        check("fail_status", readdata, 32'h0001_0314);
        check("fail_linkdis", 32'(linkdis), 32'h1);

        // Clear FAILED: IDLE, then START with enable still set.
        write_reg(2'd0, 32'h0001_0000);
        check("clr_irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("clr_irq_drop", 32'(irq), 32'h0);
        check("clr_linkstart_idle", 32'(linkstart), 32'h0);
        @(negedge clk);
        check("clr_status_idle", readdata, 32'h0);
        check("clr_linkstart_start", 32'(linkstart), 32'h1);
        @(negedge clk);
        check("clr_status_start", readdata, 32'h0000_0004);

        // Now in CONNECT: go to RUN, then a one-cycle drop with an error pulse.
        running = 1'b1;
        repeat (3) @(negedge clk);
        check("rerun_status", readdata, 32'h0000_000E);
        running  = 1'b0;
        link_err = 1'b1;
        @(negedge clk);
        running  = 1'b1;
        link_err = 1'b0;
        check("drop_linkstart", 32'(linkstart), 32'h0);
        measure(1'b0, 40, len); check("drop_backoff", 32'(len), 32'd16);
        address = 2'd3;
        @(negedge clk);
        check("drop_errcnt", readdata, 32'h1);
        address = 2'd0;
        @(negedge clk);
        check("drop_status", readdata, 32'h0002_000A);
        check("drop_irq", 32'(irq), 32'h1);

        // ERRCNT saturation and clear-wins.
        write_reg(2'd1, 32'h0);
        running = 1'b0;
        write_reg(2'd3, 32'h0);
        link_err = 1'b1;
        repeat (32'h10005) @(negedge clk);
        link_err = 1'b0;
        address  = 2'd3;
        @(negedge clk);
        check("errcnt_sat", readdata, 32'h0000_FFFF);
        address  = 2'd3;
        write    = 1'b1;
        link_err = 1'b1;
        @(negedge clk);
        write    = 1'b0;
        link_err = 1'b0;
        @(negedge clk);
        check("errcnt_clr_wins", readdata, 32'h0);

        // Disable during CONNECT.
        write_reg(2'd2, 32'd100);
        write_reg(2'd1, 32'h3);
        @(negedge clk);
        @(negedge clk);
        write_reg(2'd1, 32'h2);
        check("dis_hold", 32'(linkstart), 32'h1);
        @(negedge clk);
        check("dis_linkstart", 32'(linkstart), 32'h0);
        check("dis_linkdis", 32'(linkdis), 32'h1);

        // Asynchronous reset mid-CONNECT.
        write_reg(2'd1, 32'h3);
        address = 2'd0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_linkstart", 32'(linkstart), 32'h1);
        check("pre_rst_irq", 32'(irq), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("async_linkstart", 32'(linkstart), 32'h0);
        check("async_linkdis", 32'(linkdis), 32'h1);
        check("async_irq", 32'(irq), 32'h0);
        check("async_readdata", readdata, 32'h0);
        @(negedge clk);
        reset   = 1'b0;
        address = 2'd2;
        @(negedge clk);
        check("post_rst_timeout", readdata, 32'd1000);

        // TIMEOUT=0 fails on the first CONNECT cycle.
        write_reg(2'd2, 32'd0);
        write_reg(2'd1, 32'h1);
        @(negedge clk);
        measure(1'b1, 40, len); check("t0_high", 32'(len), 32'd2);
        measure(1'b0, 40, len); check("t0_backoff", 32'(len), 32'd16);
        write_reg(2'd1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
